// File: rtl/atomic_mem_sequencer.sv
// Memory-stage sequencer for plain and A-extension word accesses with a one-cycle tagged response.
// Optional AMO execution is built only when AMO_SUPPORT_EN is defined.
module atomic_mem_sequencer #(
   parameter int NUM_THREADS = 16,
   parameter int ADDR_W      = 12,
   parameter int DATA_W      = 32,
   localparam int HW         = $clog2(NUM_THREADS)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              i_req_valid,
   output logic              o_req_ready,
   input  logic [3:0]        i_op,
   input  logic [ADDR_W-1:0] i_addr,
   input  logic [DATA_W-1:0] i_wdata,
   input  logic [HW-1:0]     i_mhartid,
   output logic [ADDR_W-1:0] o_rsv_addr,
   output logic [HW-1:0]     o_rsv_mhartid,
   output logic              o_rsv_store_op,
   output logic              o_rsv_store_cond_op,
   output logic              o_rsv_load_reserved_op,
   input  logic              i_rsv_sc_success,
   output logic              o_mem_en,
   output logic              o_mem_we,
   output logic [ADDR_W-1:0] o_mem_addr,
   output logic [DATA_W-1:0] o_mem_wdata,
   input  logic [DATA_W-1:0] i_mem_rdata,
   output logic              o_rsp_valid,
   output logic [HW-1:0]     o_rsp_hartid,
   output logic [DATA_W-1:0] o_rsp_data,
   output logic              o_rsp_err
);
   localparam logic [3:0] OP_LOAD = 4'd0, OP_STORE = 4'd1, OP_LR = 4'd2, OP_SC = 4'd3;
   localparam logic [3:0] OP_AMOSWAP = 4'd4, OP_AMOADD = 4'd5, OP_AMOXOR = 4'd6, OP_AMOAND = 4'd7;
   localparam logic [3:0] OP_AMOOR = 4'd8, OP_AMOMIN = 4'd9, OP_AMOMAX = 4'd10;
   localparam logic [3:0] OP_AMOMINU = 4'd11, OP_AMOMAXU = 4'd12;

`ifdef AMO_SUPPORT_EN
   localparam bit AMO_EN = 1'b1;
`else
   localparam bit AMO_EN = 1'b0;
`endif

   typedef enum logic [2:0] {
      S_IDLE,
      S_ISSUE,
      S_RD_WAIT,
      S_SC_WAIT,
`ifdef AMO_SUPPORT_EN
      S_AMO_WR,
`endif
      S_RESP
   } state_t;

   state_t            state;
   logic [3:0]        op_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic [HW-1:0]     hart_q;
   logic              rsv_store_q, rsv_sc_q, rsv_lr_q;
   logic              mem_en_q, mem_we_q;
   logic [DATA_W-1:0] mem_wdata_q;
   logic              rsp_valid_q, rsp_err_q;
   logic [HW-1:0]     rsp_hartid_q;
   logic [DATA_W-1:0] rsp_data_q;
   logic              sc_write;

   function automatic logic op_is_amo(input logic [3:0] op);
      return AMO_EN && (op >= OP_AMOSWAP) && (op <= OP_AMOMAXU);
   endfunction

`ifdef AMO_SUPPORT_EN
   logic [DATA_W-1:0] old_q;

   function automatic logic [DATA_W-1:0] amo_result(input logic [3:0] op,
                                                    input logic [DATA_W-1:0] a,
                                                    input logic [DATA_W-1:0] b);
      logic s_lt, u_lt;
      s_lt = $signed(a) < $signed(b);
      u_lt = a < b;
      case (op)
         OP_AMOSWAP: return b;
         OP_AMOADD:  return a + b;
         OP_AMOXOR:  return a ^ b;
         OP_AMOAND:  return a & b;
         OP_AMOOR:   return a | b;
         OP_AMOMIN:  return s_lt ? a : b;
         OP_AMOMAX:  return s_lt ? b : a;
         OP_AMOMINU: return u_lt ? a : b;
         OP_AMOMAXU: return u_lt ? b : a;
         default:    return a;
      endcase
   endfunction
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= S_IDLE;
         op_q         <= '0;
         addr_q       <= '0;
         wdata_q      <= '0;
         hart_q       <= '0;
         rsv_store_q  <= 1'b0;
         rsv_sc_q     <= 1'b0;
         rsv_lr_q     <= 1'b0;
         mem_en_q     <= 1'b0;
         mem_we_q     <= 1'b0;
         mem_wdata_q  <= '0;
         rsp_valid_q  <= 1'b0;
         rsp_err_q    <= 1'b0;
         rsp_hartid_q <= '0;
         rsp_data_q   <= '0;
`ifdef AMO_SUPPORT_EN
         old_q        <= '0;
`endif
      end else begin
         // Strobes and the response are single-cycle pulses; each state re-asserts what it needs.
         rsv_store_q  <= 1'b0;
         rsv_sc_q     <= 1'b0;
         rsv_lr_q     <= 1'b0;
         mem_en_q     <= 1'b0;
         mem_we_q     <= 1'b0;
         rsp_valid_q  <= 1'b0;
         rsp_err_q    <= 1'b0;
         rsp_hartid_q <= '0;
         rsp_data_q   <= '0;
         case (state)
            S_IDLE: begin
               if (i_req_valid) begin
                  state   <= S_ISSUE;
                  op_q    <= i_op;
                  addr_q  <= i_addr;
                  wdata_q <= i_wdata;
                  hart_q  <= i_mhartid;
                  case (i_op)
                     OP_LOAD:  mem_en_q <= 1'b1;
                     OP_STORE: begin
                        mem_en_q    <= 1'b1;
                        mem_we_q    <= 1'b1;
                        mem_wdata_q <= i_wdata;
                        rsv_store_q <= 1'b1;
                     end
                     OP_LR: begin
                        mem_en_q <= 1'b1;
                        rsv_lr_q <= 1'b1;
                     end
                     OP_SC:    rsv_sc_q <= 1'b1;
                     default:  mem_en_q <= op_is_amo(i_op);
                  endcase
               end
            end
            S_ISSUE: begin
               if (op_q == OP_SC) begin
                  state <= S_SC_WAIT;
               end else if (op_q == OP_LOAD || op_q == OP_LR || op_is_amo(op_q)) begin
                  state <= S_RD_WAIT;
               end else begin
                  state        <= S_RESP;
                  rsp_valid_q  <= 1'b1;
                  rsp_hartid_q <= hart_q;
                  rsp_err_q    <= (op_q != OP_STORE);
               end
            end
            S_RD_WAIT: begin
`ifdef AMO_SUPPORT_EN
               if (op_is_amo(op_q)) begin
                  state       <= S_AMO_WR;
                  old_q       <= i_mem_rdata;
                  mem_en_q    <= 1'b1;
                  mem_we_q    <= 1'b1;
                  mem_wdata_q <= amo_result(op_q, i_mem_rdata, wdata_q);
                  rsv_store_q <= 1'b1;
               end else
`endif
               begin
                  state        <= S_RESP;
                  rsp_valid_q  <= 1'b1;
                  rsp_hartid_q <= hart_q;
                  rsp_data_q   <= i_mem_rdata;
               end
            end
            S_SC_WAIT: begin
               state        <= S_RESP;
               rsp_valid_q  <= 1'b1;
               rsp_hartid_q <= hart_q;
               rsp_data_q   <= {{(DATA_W-1){1'b0}}, ~i_rsv_sc_success};
            end
`ifdef AMO_SUPPORT_EN
            S_AMO_WR: begin
               state        <= S_RESP;
               rsp_valid_q  <= 1'b1;
               rsp_hartid_q <= hart_q;
               rsp_data_q   <= old_q;
            end
`endif
            S_RESP:  state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

   // The SC flag only arrives during SC_WAIT, so the conditional write is decoded from it directly.
   assign sc_write = (state == S_SC_WAIT) && i_rsv_sc_success;

   assign o_req_ready            = (state == S_IDLE);
   assign o_rsv_addr             = addr_q;
   assign o_rsv_mhartid          = hart_q;
   assign o_rsv_store_op         = rsv_store_q;
   assign o_rsv_store_cond_op    = rsv_sc_q;
   assign o_rsv_load_reserved_op = rsv_lr_q;
   assign o_mem_en               = mem_en_q | sc_write;
   assign o_mem_we               = mem_we_q | sc_write;
   assign o_mem_addr             = addr_q;
   assign o_mem_wdata            = sc_write ? wdata_q : mem_wdata_q;
   assign o_rsp_valid            = rsp_valid_q;
   assign o_rsp_hartid           = rsp_hartid_q;
   assign o_rsp_data             = rsp_data_q;
   assign o_rsp_err              = rsp_err_q;
endmodule

// File: tb/tb_atomic_mem_sequencer.sv
// Directed bench for atomic_mem_sequencer: word memory and reservation-set stubs, a vector table,
// and hand sequences for back-to-back issue and reset mid-operation. Honors AMO_SUPPORT_EN.
module tb_atomic_mem_sequencer;
   localparam int NT = 16, AW = 12, DW = 32, HW = 4, NV = 18;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          i_req_valid, o_req_ready;
   logic [3:0]    i_op;
   logic [AW-1:0] i_addr, o_rsv_addr, o_mem_addr;
   logic [DW-1:0] i_wdata, o_mem_wdata, o_rsp_data;
   logic [DW-1:0] i_mem_rdata = '0;
   logic [HW-1:0] i_mhartid, o_rsv_mhartid, o_rsp_hartid;
   logic          o_rsv_store_op, o_rsv_store_cond_op, o_rsv_load_reserved_op;
   logic          i_rsv_sc_success = 1'b0;
   logic          o_mem_en, o_mem_we, o_rsp_valid, o_rsp_err;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   atomic_mem_sequencer #(.NUM_THREADS(NT), .ADDR_W(AW), .DATA_W(DW)) dut (
      .clk(clk), .reset(reset),
      .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
      .i_op(i_op), .i_addr(i_addr), .i_wdata(i_wdata), .i_mhartid(i_mhartid),
      .o_rsv_addr(o_rsv_addr), .o_rsv_mhartid(o_rsv_mhartid),
      .o_rsv_store_op(o_rsv_store_op), .o_rsv_store_cond_op(o_rsv_store_cond_op),
      .o_rsv_load_reserved_op(o_rsv_load_reserved_op), .i_rsv_sc_success(i_rsv_sc_success),
      .o_mem_en(o_mem_en), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
      .o_mem_wdata(o_mem_wdata), .i_mem_rdata(i_mem_rdata),
      .o_rsp_valid(o_rsp_valid), .o_rsp_hartid(o_rsp_hartid),
      .o_rsp_data(o_rsp_data), .o_rsp_err(o_rsp_err)
   );

   // Word memory: read data appears the cycle after a read enable.
   logic [DW-1:0] mem [0:4095];
   logic          mem_load = 1'b0;
   always @(posedge clk) begin
      if (mem_load) begin
         for (int i = 0; i < 4096; i++) mem[i] <= '0;
         mem[12'h040] <= 32'h0000_0011;
         mem[12'h100] <= 32'h7FFF_FFFF;
         mem[12'h101] <= 32'hFFFF_FFFF;
         mem[12'h102] <= 32'hFFFF_FFFF;
         mem[12'h200] <= 32'hDEAD_BEEF;
      end else if (o_mem_en) begin
         if (o_mem_we) mem[o_mem_addr] <= o_mem_wdata;
         else          i_mem_rdata <= mem[o_mem_addr];
      end
   end

   // Reservation set stub: one reservation per hart, registered SC verdict.
   logic          rv [NT];
   logic [AW-1:0] ra [NT];
   always @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NT; i++) rv[i] <= 1'b0;
         i_rsv_sc_success <= 1'b0;
      end else begin
         i_rsv_sc_success <= 1'b0;
         if (o_rsv_load_reserved_op) begin
            rv[o_rsv_mhartid] <= 1'b1;
            ra[o_rsv_mhartid] <= o_rsv_addr;
         end
         if (o_rsv_store_op)
            for (int i = 0; i < NT; i++)
               if (rv[i] && ra[i] == o_rsv_addr) rv[i] <= 1'b0;
         if (o_rsv_store_cond_op) begin
            i_rsv_sc_success <= rv[o_rsv_mhartid] && (ra[o_rsv_mhartid] == o_rsv_addr);
            rv[o_rsv_mhartid] <= 1'b0;
         end
      end
   end

   typedef struct {
      logic [3:0]    op;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
      logic [HW-1:0] hart;
      logic          amo;
      logic [DW-1:0] exp_data;
      logic          exp_err;
      int            exp_lat;
      int            exp_en;
      int            exp_we;
      int            exp_strb;  // store*100 + sc*10 + lr pulse counts
      logic [DW-1:0] exp_mem;
   } vec_t;

   vec_t vecs [NV];

   function automatic vec_t mk(input logic [3:0] op, input logic [AW-1:0] addr,
                               input logic [DW-1:0] wdata, input logic [HW-1:0] hart,
                               input logic amo, input logic [DW-1:0] data, input logic err,
                               input int lat, input int en, input int we, input int strb,
                               input logic [DW-1:0] memv);
      vec_t v;
      v.op = op; v.addr = addr; v.wdata = wdata; v.hart = hart; v.amo = amo;
      v.exp_data = data; v.exp_err = err; v.exp_lat = lat; v.exp_en = en;
      v.exp_we = we; v.exp_strb = strb; v.exp_mem = memv;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got=%h want=%h", name, act, exp);
      end
   endtask

   task automatic run_req(input int idx, input vec_t v);
      vec_t e;
      int lat, en_n, we_n, strb;
      logic dirty, rdy_bad;
      logic [DW-1:0] r_data;
      logic [HW-1:0] r_hart;
      logic r_err;
      e = v;
`ifndef AMO_SUPPORT_EN
      if (v.amo) begin
         e.exp_data = '0; e.exp_err = 1'b1; e.exp_lat = 2; e.exp_en = 0;
         e.exp_we = 0; e.exp_strb = 0; e.exp_mem = mem[v.addr];
      end
`endif
      @(negedge clk);
      chk($sformatf("v%0d ready_idle", idx), 32'(o_req_ready), 32'd1);
      i_req_valid = 1'b1; i_op = v.op; i_addr = v.addr; i_wdata = v.wdata; i_mhartid = v.hart;
      @(posedge clk);
      #1 i_req_valid = 1'b0;
      lat = 0; en_n = 0; we_n = 0; strb = 0; dirty = 1'b0; rdy_bad = 1'b0;
      r_data = '0; r_hart = '0; r_err = 1'b0;
      for (int c = 1; c <= 8; c++) begin
         @(negedge clk);
         en_n += o_mem_en ? 1 : 0;
         we_n += o_mem_we ? 1 : 0;
         strb += (o_rsv_store_op ? 100 : 0) + (o_rsv_store_cond_op ? 10 : 0)
               + (o_rsv_load_reserved_op ? 1 : 0);
         if (o_req_ready) rdy_bad = 1'b1;
         if (o_rsp_valid) begin
            lat = c; r_data = o_rsp_data; r_hart = o_rsp_hartid; r_err = o_rsp_err;
            break;
         end
         if (o_rsp_data != '0 || o_rsp_err || o_rsp_hartid != '0) dirty = 1'b1;
      end
      chk($sformatf("v%0d latency", idx), 32'(lat), 32'(e.exp_lat));
      chk($sformatf("v%0d rsp_data", idx), r_data, e.exp_data);
      chk($sformatf("v%0d rsp_err", idx), 32'(r_err), 32'(e.exp_err));
      chk($sformatf("v%0d rsp_hartid", idx), 32'(r_hart), 32'(v.hart));
      chk($sformatf("v%0d mem_en_cycles", idx), 32'(en_n), 32'(e.exp_en));
      chk($sformatf("v%0d mem_we_cycles", idx), 32'(we_n), 32'(e.exp_we));
      chk($sformatf("v%0d rsv_strobes", idx), 32'(strb), 32'(e.exp_strb));
      chk($sformatf("v%0d rsp_idle_zero", idx), 32'(dirty), 32'd0);
      chk($sformatf("v%0d ready_busy", idx), 32'(rdy_bad), 32'd0);
      @(negedge clk);
      chk($sformatf("v%0d rsp_pulse", idx), 32'(o_rsp_valid), 32'd0);
      chk($sformatf("v%0d mem_after", idx), mem[v.addr], e.exp_mem);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired got=timeout want=finish");
      $fatal(1);
   end

   initial begin
      int r1, r2, rdy3;
      logic [HW-1:0] h1, h2;
      logic bad_we, bad_rsp, bad_strb, rdy_a, rdy_b;
      logic [DW-1:0] pre;

      //          op     addr     wdata         hart amo data          err lat en we strb mem
      vecs[0]  = mk(4'd2,  12'h040, 32'h0,        4'd3,  0, 32'h11,       0, 3, 1, 0, 1,   32'h11);
      vecs[1]  = mk(4'd3,  12'h040, 32'h22,       4'd3,  0, 32'h0,        0, 3, 1, 1, 10,  32'h22);
      vecs[2]  = mk(4'd2,  12'h010, 32'h0,        4'd2,  0, 32'h0,        0, 3, 1, 0, 1,   32'h0);
      vecs[3]  = mk(4'd1,  12'h010, 32'h5,        4'd5,  0, 32'h0,        0, 2, 1, 1, 100, 32'h5);
      vecs[4]  = mk(4'd3,  12'h010, 32'h9,        4'd2,  0, 32'h1,        0, 3, 0, 0, 10,  32'h5);
      vecs[5]  = mk(4'd0,  12'h200, 32'h0,        4'd7,  0, 32'hDEADBEEF, 0, 3, 1, 0, 0,   32'hDEADBEEF);
      vecs[6]  = mk(4'd14, 12'h200, 32'h1,        4'd15, 0, 32'h0,        1, 2, 0, 0, 0,   32'hDEADBEEF);
      vecs[7]  = mk(4'd15, 12'h040, 32'h1,        4'd1,  0, 32'h0,        1, 2, 0, 0, 0,   32'h22);
      vecs[8]  = mk(4'd13, 12'h010, 32'h1,        4'd12, 0, 32'h0,        1, 2, 0, 0, 0,   32'h5);
      vecs[9]  = mk(4'd5,  12'h100, 32'h1,        4'd1,  1, 32'h7FFFFFFF, 0, 4, 2, 1, 100, 32'h80000000);
      vecs[10] = mk(4'd9,  12'h101, 32'h1,        4'd4,  1, 32'hFFFFFFFF, 0, 4, 2, 1, 100, 32'hFFFFFFFF);
      vecs[11] = mk(4'd11, 12'h102, 32'h1,        4'd4,  1, 32'hFFFFFFFF, 0, 4, 2, 1, 100, 32'h1);
      vecs[12] = mk(4'd4,  12'h200, 32'h12345678, 4'd9,  1, 32'hDEADBEEF, 0, 4, 2, 1, 100, 32'h12345678);
      vecs[13] = mk(4'd6,  12'h040, 32'hFF,       4'd0,  1, 32'h22,       0, 4, 2, 1, 100, 32'hDD);
      vecs[14] = mk(4'd7,  12'h040, 32'h0F,       4'd0,  1, 32'hDD,       0, 4, 2, 1, 100, 32'h0D);
      vecs[15] = mk(4'd8,  12'h040, 32'hF0,       4'd0,  1, 32'h0D,       0, 4, 2, 1, 100, 32'hFD);
      vecs[16] = mk(4'd10, 12'h101, 32'h5,        4'd8,  1, 32'hFFFFFFFF, 0, 4, 2, 1, 100, 32'h5);
      vecs[17] = mk(4'd12, 12'h102, 32'h80000000, 4'd6,  1, 32'h1,        0, 4, 2, 1, 100, 32'h80000000);

      i_req_valid = 1'b0; i_op = '0; i_addr = '0; i_wdata = '0; i_mhartid = '0;
      mem_load = 1'b1;
      repeat (3) @(posedge clk);
      #1 mem_load = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      chk("reset ready", 32'(o_req_ready), 32'd1);
      chk("reset rsp_valid", 32'(o_rsp_valid), 32'd0);
      chk("reset mem_en", 32'(o_mem_en), 32'd0);
      chk("reset mem_we", 32'(o_mem_we), 32'd0);
      chk("reset strobes", 32'({o_rsv_store_op, o_rsv_store_cond_op, o_rsv_load_reserved_op}), 32'd0);
      chk("reset rsp_data", o_rsp_data, 32'd0);
      chk("reset rsp_err", 32'(o_rsp_err), 32'd0);

      for (int k = 0; k < NV; k++) run_req(k, vecs[k]);

      // Back-to-back stores with i_req_valid held high.
      @(negedge clk);
      i_req_valid = 1'b1; i_op = 4'd1; i_addr = 12'h300; i_wdata = 32'hA1; i_mhartid = 4'd10;
      @(posedge clk);
      #1 i_addr = 12'h301; i_wdata = 32'hB2; i_mhartid = 4'd11;
      r1 = 0; r2 = 0; rdy3 = 0; h1 = '0; h2 = '0;
      for (int c = 1; c <= 10; c++) begin
         @(negedge clk);
         if (c == 3) rdy3 = o_req_ready ? 1 : 0;
         if (c == 4) i_req_valid = 1'b0;
         if (o_rsp_valid) begin
            if (r1 == 0) begin r1 = c; h1 = o_rsp_hartid; end
            else if (r2 == 0) begin r2 = c; h2 = o_rsp_hartid; end
         end
      end
      chk("b2b rsp1_cycle", 32'(r1), 32'd2);
      chk("b2b rsp1_hart", 32'(h1), 32'd10);
      chk("b2b ready_after_resp", 32'(rdy3), 32'd1);
      chk("b2b rsp2_cycle", 32'(r2), 32'd5);
      chk("b2b rsp2_hart", 32'(h2), 32'd11);
      chk("b2b mem300", mem[12'h300], 32'hA1);
      chk("b2b mem301", mem[12'h301], 32'hB2);

      // Reset while the read of an AMO (plain load without AMO support) is outstanding.
      @(negedge clk);
      pre = mem[12'h100];
`ifdef AMO_SUPPORT_EN
      i_op = 4'd5;
`else
      i_op = 4'd0;
`endif
      i_req_valid = 1'b1; i_addr = 12'h100; i_wdata = 32'h1; i_mhartid = 4'd2;
      @(posedge clk);
      #1 i_req_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
      bad_we = 1'b0; bad_rsp = 1'b0; bad_strb = 1'b0; rdy_a = 1'b0; rdy_b = 1'b0;
      for (int c = 3; c <= 8; c++) begin
         @(negedge clk);
         if (o_mem_we) bad_we = 1'b1;
         if (o_rsp_valid) bad_rsp = 1'b1;
         if (o_rsv_store_op || o_rsv_store_cond_op || o_rsv_load_reserved_op) bad_strb = 1'b1;
         if (c == 3) begin rdy_a = o_req_ready; reset = 1'b0; end
         if (c == 4) rdy_b = o_req_ready;
      end
      chk("rst_mid no_mem_we", 32'(bad_we), 32'd0);
      chk("rst_mid no_rsp", 32'(bad_rsp), 32'd0);
      chk("rst_mid no_strobes", 32'(bad_strb), 32'd0);
      chk("rst_mid ready_in_reset", 32'(rdy_a), 32'd1);
      chk("rst_mid ready_after", 32'(rdy_b), 32'd1);
      chk("rst_mid mem_kept", mem[12'h100], pre);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
